// File: rtl/vdp_port_writer.sv
// Drives the VDP control (0xBF) and data (0xBE) ports from a command interface.
// Each write uses one clk_en slot. An optional idle gap can follow each write.
module vdp_port_writer #(
  parameter int C_GAP      = 0,
  parameter int C_LEN_BITS = 14
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clk_en,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [3:0]            cmd_reg,
  input  logic [13:0]           cmd_addr,
  input  logic [7:0]            cmd_data,
  input  logic [C_LEN_BITS-1:0] cmd_len,
  input  logic                  data_valid,
  input  logic [7:0]            data_in,
  output logic                  data_ready,
  output logic [7:0]            io_addr,
  output logic [7:0]            io_data,
  output logic                  io_wr,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {S_IDLE, S_CTRL0, S_CTRL1, S_DATA, S_GAP} state_t;

  localparam logic [1:0] OP_SETREG  = 2'd0;
  localparam logic [1:0] OP_SETADDR = 2'd1;
  localparam logic [1:0] OP_STREAM  = 2'd3;
  localparam logic [7:0] PORT_CTRL  = 8'hBF;
  localparam logic [7:0] PORT_DATA  = 8'hBE;
  localparam logic [3:0] GAP_N      = 4'(C_GAP);
  localparam logic [C_LEN_BITS-1:0] LEN_ONE = 1;

  state_t                state_q, state_d, ret_q, ret_d, adv_to;
  logic [1:0]            op_q, op_d;
  logic [3:0]            reg_q, reg_d;
  logic [13:0]           addr_q, addr_d;
  logic [7:0]            data_q, data_d;
  logic [C_LEN_BITS-1:0] cnt_q, cnt_d;
  logic [3:0]            gap_q, gap_d;
  logic [7:0]            io_addr_q, io_addr_d;
  logic [7:0]            io_data_q, io_data_d;
  logic                  done_q, done_d;
  logic                  wr, adv, is_stream;

  assign is_stream = (op_q == OP_STREAM);

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    op_d      = op_q;
    reg_d     = reg_q;
    addr_d    = addr_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    io_addr_d = io_addr_q;
    io_data_d = io_data_q;
    done_d    = 1'b0;
    wr        = 1'b0;
    adv       = 1'b0;
    adv_to    = S_IDLE;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d      = cmd_op;
          reg_d     = cmd_reg;
          addr_d    = cmd_addr;
          data_d    = cmd_data;
          cnt_d     = cmd_len;
          state_d   = S_CTRL0;
          io_addr_d = PORT_CTRL;
          io_data_d = (cmd_op == OP_SETREG) ? cmd_data : cmd_addr[7:0];
        end
      end
      S_CTRL0: begin
        if (clk_en) begin
          wr        = 1'b1;
          adv       = 1'b1;
          adv_to    = S_CTRL1;
          io_addr_d = PORT_CTRL;
          io_data_d = (op_q == OP_SETREG) ? {4'b1000, reg_q} : {2'b01, addr_q[13:8]};
        end
      end
      S_CTRL1: begin
        if (clk_en) begin
          wr = 1'b1;
          if (op_q == OP_SETREG || op_q == OP_SETADDR || cnt_q == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            adv       = 1'b1;
            adv_to    = S_DATA;
            io_addr_d = PORT_DATA;
            io_data_d = data_q;
          end
        end
      end
      S_DATA: begin
        // A stream slot without a byte is skipped and leaves the count alone.
        if (clk_en && (!is_stream || data_valid)) begin
          wr    = 1'b1;
          cnt_d = cnt_q - LEN_ONE;
          if (cnt_q == LEN_ONE) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            adv    = 1'b1;
            adv_to = S_DATA;
          end
        end
      end
      S_GAP: begin
        if (clk_en) begin
          gap_d = gap_q - 4'd1;
          if (gap_q <= 4'd1) begin
            state_d = ret_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (adv) begin
      if (C_GAP > 0) begin
        state_d = S_GAP;
        ret_d   = adv_to;
        gap_d   = GAP_N;
      end else begin
        state_d = adv_to;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      ret_q     <= S_IDLE;
      op_q      <= 2'd0;
      reg_q     <= 4'd0;
      addr_q    <= 14'd0;
      data_q    <= 8'd0;
      cnt_q     <= '0;
      gap_q     <= 4'd0;
      io_addr_q <= 8'd0;
      io_data_q <= 8'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      op_q      <= op_d;
      reg_q     <= reg_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      io_addr_q <= io_addr_d;
      io_data_q <= io_data_d;
      done_q    <= done_d;
    end
  end

  // Stream bytes go straight through so io_data matches data_in on the strobe.
  assign io_data    = (state_q == S_DATA && is_stream) ? data_in : io_data_q;
  assign io_addr    = io_addr_q;
  assign io_wr      = wr && reset_n;
  assign data_ready = wr && reset_n && (state_q == S_DATA) && is_stream;
  assign busy       = (state_q != S_IDLE);
  assign cmd_ready  = (state_q == S_IDLE);
  assign done       = done_q;

endmodule

// File: tb/tb_vdp_port_writer.sv
// Directed bench for vdp_port_writer: one instance with no gap, one with a 2-slot gap.
module tb_vdp_port_writer;
  logic        clk = 1'b0;
  logic        reset_n, clk_en;
  logic        cmd_valid0, cmd_valid2;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_reg;
  logic [13:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic [13:0] cmd_len;
  logic        data_valid;
  logic [7:0]  data_in;
  logic        cmd_ready0, data_ready0, io_wr0, busy0, done0;
  logic [7:0]  io_addr0, io_data0;
  logic        cmd_ready2, data_ready2, io_wr2, busy2, done2;
  logic [7:0]  io_addr2, io_data2;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int en_period = 1;
  int en_cnt = 0;

  logic [15:0] wr_log0[$];
  int          wr_cyc0[$];
  logic [15:0] wr_log2[$];
  int done_cyc0 = 0;
  int dr_cnt = 0, dr_bad = 0, consec0 = 0, gap2 = 0, stall_wr = 0;
  logic prev_wr0 = 1'b0;

  vdp_port_writer #(.C_GAP(0), .C_LEN_BITS(14)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
    .cmd_op(cmd_op), .cmd_reg(cmd_reg), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_len(cmd_len),
    .data_valid(data_valid), .data_in(data_in), .data_ready(data_ready0),
    .io_addr(io_addr0), .io_data(io_data0), .io_wr(io_wr0), .busy(busy0), .done(done0));

  vdp_port_writer #(.C_GAP(2), .C_LEN_BITS(14)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_op(cmd_op), .cmd_reg(cmd_reg), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_len(cmd_len),
    .data_valid(data_valid), .data_in(data_in), .data_ready(data_ready2),
    .io_addr(io_addr2), .io_data(io_data2), .io_wr(io_wr2), .busy(busy2), .done(done2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    clk_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      en_cnt++;
      if (en_cnt >= en_period) begin
        en_cnt = 0;
        clk_en = 1'b1;
      end else begin
        clk_en = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (io_wr0) begin
      wr_log0.push_back({io_addr0, io_data0});
      wr_cyc0.push_back(cyc);
    end
    if (io_wr0 && prev_wr0) consec0++;
    prev_wr0 = io_wr0;
    if (data_ready0) dr_cnt++;
    if (data_ready0 && !io_wr0) dr_bad++;
    if (done0) done_cyc0 = cyc;
    if (io_wr2) wr_log2.push_back({io_addr2, io_data2});
    if (clk_en && busy2 && !io_wr2) gap2++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] log0(input int i);
    return (wr_log0.size() > i) ? wr_log0[i] : 16'hDEAD;
  endfunction

  function automatic logic [15:0] log2(input int i);
    return (wr_log2.size() > i) ? wr_log2[i] : 16'hDEAD;
  endfunction

  function automatic int wcyc0(input int i);
    return (wr_cyc0.size() > i) ? wr_cyc0[i] : -1000;
  endfunction

  task automatic clear_logs();
    wr_log0.delete();
    wr_cyc0.delete();
    wr_log2.delete();
    dr_cnt = 0;
    dr_bad = 0;
    gap2 = 0;
  endtask

  task automatic issue(input bit which, input logic [1:0] op, input logic [3:0] rg,
                       input logic [13:0] addr, input logic [7:0] dat, input logic [13:0] len);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    cmd_op = op; cmd_reg = rg; cmd_addr = addr; cmd_data = dat; cmd_len = len;
    if (which) cmd_valid2 = 1'b1; else cmd_valid0 = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((which ? cmd_ready2 : cmd_ready0) == 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid0 = 1'b0;
    cmd_valid2 = 1'b0;
    // Scramble the command bus: the block must work from its latched copy.
    cmd_op = ~op; cmd_reg = ~rg; cmd_addr = ~addr; cmd_data = ~dat; cmd_len = 14'h3FFF;
  endtask

  task automatic wait_done(input bit which, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ((which ? done2 : done0) == 1'b1) begin
        ok = 1'b1;
        check({tag, "_ready_at_done"}, 32'(which ? cmd_ready2 : cmd_ready0), 32'd1);
        break;
      end
    end
    check({tag, "_done_seen"}, 32'(ok), 32'd1);
    #1;
  endtask

  task automatic wait_dr(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (data_ready0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({tag, "_ready_timeout"}, 32'(ok), 32'd1);
  endtask

  initial begin
    reset_n = 1'b0;
    cmd_valid0 = 1'b0; cmd_valid2 = 1'b0;
    cmd_op = 2'd0; cmd_reg = 4'd0; cmd_addr = 14'd0; cmd_data = 8'd0; cmd_len = 14'd0;
    data_valid = 1'b0; data_in = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_io_wr", 32'(io_wr0), 0);
    check("rst_io_addr", 32'(io_addr0), 0);
    check("rst_io_data", 32'(io_data0), 0);
    check("rst_busy", 32'(busy0), 0);
    check("rst_done", 32'(done0), 0);
    check("rst_data_ready", 32'(data_ready0), 0);
    check("rst_cmd_ready", 32'(cmd_ready0), 1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // SETREG reg 1 = 0x60 with clk_en every 7 clocks
    en_period = 7;
    clear_logs();
    issue(0, 2'd0, 4'd1, 14'h0000, 8'h60, 14'd0);
    wait_done(0, "setreg");
    check("setreg_count", 32'(wr_log0.size()), 2);
    check("setreg_w0", 32'(log0(0)), 32'hBF60);
    check("setreg_w1", 32'(log0(1)), 32'hBF81);
    check("setreg_spacing", 32'(wcyc0(1) - wcyc0(0)), 7);
    check("setreg_done_lag", 32'(done_cyc0 - wcyc0(1)), 1);

    // SETADDR 0x3F00
    en_period = 3;
    clear_logs();
    issue(0, 2'd1, 4'd0, 14'h3F00, 8'h00, 14'd5);
    wait_done(0, "setaddr");
    check("setaddr_count", 32'(wr_log0.size()), 2);
    check("setaddr_w0", 32'(log0(0)), 32'hBF00);
    check("setaddr_w1", 32'(log0(1)), 32'hBF7F);
    check("setaddr_busy_after", 32'(busy0), 0);

    // FILL 4 bytes of 0xAA at 0x0000
    clear_logs();
    issue(0, 2'd2, 4'd0, 14'h0000, 8'hAA, 14'd4);
    wait_done(0, "fill");
    check("fill_count", 32'(wr_log0.size()), 6);
    check("fill_w0", 32'(log0(0)), 32'hBF00);
    check("fill_w1", 32'(log0(1)), 32'hBF40);
    for (int i = 2; i < 6; i++) check($sformatf("fill_w%0d", i), 32'(log0(i)), 32'hBEAA);
    check("fill_done_lag", 32'(done_cyc0 - wcyc0(5)), 1);

    // FILL with len 0: address setup only
    clear_logs();
    issue(0, 2'd2, 4'd0, 14'h1234, 8'hAA, 14'd0);
    wait_done(0, "fill0");
    check("fill0_count", 32'(wr_log0.size()), 2);
    check("fill0_w0", 32'(log0(0)), 32'hBF34);
    check("fill0_w1", 32'(log0(1)), 32'hBF52);

    // STREAM 3 bytes with a 2-slot stall before the second byte
    clear_logs();
    stall_wr = 0;
    data_valid = 1'b1;
    data_in = 8'h11;
    issue(0, 2'd3, 4'd0, 14'h0100, 8'h00, 14'd3);
    wait_dr("s1");
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (clk_en) begin
          if (io_wr0) stall_wr++;
          break;
        end
      end
    end
    @(posedge clk);
    #1;
    data_valid = 1'b1;
    data_in = 8'h22;
    wait_dr("s2");
    @(posedge clk);
    #1;
    data_in = 8'h33;
    wait_dr("s3");
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    wait_done(0, "stream");
    check("stream_count", 32'(wr_log0.size()), 5);
    check("stream_w0", 32'(log0(0)), 32'hBF00);
    check("stream_w1", 32'(log0(1)), 32'hBF41);
    check("stream_w2", 32'(log0(2)), 32'hBE11);
    check("stream_w3", 32'(log0(3)), 32'hBE22);
    check("stream_w4", 32'(log0(4)), 32'hBE33);
    check("stream_stall_writes", 32'(stall_wr), 0);
    check("stream_dr_count", 32'(dr_cnt), 3);
    check("stream_dr_without_wr", 32'(dr_bad), 0);

    // Gap of 2 slots, FILL 2 bytes
    en_period = 2;
    clear_logs();
    issue(1, 2'd2, 4'd0, 14'h0005, 8'h5A, 14'd2);
    wait_done(1, "gap");
    check("gap_count", 32'(wr_log2.size()), 4);
    check("gap_w0", 32'(log2(0)), 32'hBF05);
    check("gap_w1", 32'(log2(1)), 32'hBF40);
    check("gap_w2", 32'(log2(2)), 32'hBE5A);
    check("gap_w3", 32'(log2(3)), 32'hBE5A);
    check("gap_slots", 32'(gap2), 6);

    // Reset between the CTRL0 and CTRL1 writes
    en_period = 7;
    clear_logs();
    issue(0, 2'd0, 4'd2, 14'h0000, 8'h33, 14'd0);
    begin
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (io_wr0) begin
          ok = 1'b1;
          break;
        end
      end
      check("rstmid_first_write", 32'(ok), 1);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(negedge clk);
    check("rstmid_wr_in_reset", 32'(io_wr0), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("rstmid_io_addr", 32'(io_addr0), 0);
    check("rstmid_io_data", 32'(io_data0), 0);
    check("rstmid_busy", 32'(busy0), 0);
    check("rstmid_done", 32'(done0), 0);
    check("rstmid_cmd_ready", 32'(cmd_ready0), 1);
    repeat (30) @(posedge clk);
    #1;
    check("rstmid_no_more_writes", 32'(wr_log0.size()), 1);
    check("rstmid_w0", 32'(log0(0)), 32'hBF33);

    // Register index above 10 passes through unchanged
    en_period = 3;
    clear_logs();
    issue(0, 2'd0, 4'd11, 14'h0000, 8'hC3, 14'd0);
    wait_done(0, "reg11");
    check("reg11_count", 32'(wr_log0.size()), 2);
    check("reg11_w0", 32'(log0(0)), 32'hBFC3);
    check("reg11_w1", 32'(log0(1)), 32'hBF8B);
    check("no_back_to_back_wr", 32'(consec0), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/vdp_port_writer.md
# vdp_port_writer

Bus-initiator block that drives the VDP I/O port protocol (control port 0xBF, data port 0xBE) from a command interface rather than from the Z80. It converts high-level commands (register write, VRAM address set, VRAM fill, VRAM stream) into the exact byte sequences the VDP port decoder in the SMS top level expects. Each port write is paced by the CPU clock-edge strobe. It sits beside the CPU on the I/O write path and is used for OSD/ESP32-driven VRAM loading and for VDP bring-up without ROM code.

## Interface
- C_GAP, 0, number of idle `clk_en` slots inserted between consecutive port writes (0–15)
- C_LEN_BITS, 14, width of the byte-count field

- clk  in  1  system clock (cpuClock domain)
- reset_n  in  1  reset, synchronous, active-low
- clk_en  in  1  write-slot strobe (cpuClockEdge); at most one port write per high cycle
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when `cmd_valid && cmd_ready`
- cmd_op  in  2  0=SETREG, 1=SETADDR, 2=FILL, 3=STREAM
- cmd_reg  in  4  VDP register index (SETREG)
- cmd_addr  in  14  VRAM address (SETADDR/FILL/STREAM)
- cmd_data  in  8  register value (SETREG) or fill byte (FILL)
- cmd_len  in  C_LEN_BITS  data-byte count (FILL/STREAM); 0 = address setup only
- data_valid  in  1  stream byte present
- data_in  in  8  stream byte
- data_ready  out  1  stream byte consumed this cycle
- io_addr  out  8  port number (0xBF or 0xBE)
- io_data  out  8  byte written
- io_wr  out  1  port write strobe, one cycle
- busy  out  1  command in progress
- done  out  1  one-cycle pulse on command completion

## Operation
- States: IDLE, CTRL0, CTRL1, DATA, GAP.
- IDLE: `cmd_ready`=1. On accept, latch op/reg/addr/data/len into internal registers and go to CTRL0. Later changes on cmd_* inputs are ignored.
- CTRL0: io_addr=0xBF. io_data = cmd_data for SETREG, otherwise addr[7:0].
- CTRL1: io_addr=0xBF. io_data = {2'b10,2'b00,reg} for SETREG, otherwise {2'b01,addr[13:8]}.
- After CTRL1:
  - SETREG, SETADDR, or len==0: go to IDLE and pulse `done`.
  - Otherwise go to DATA.
- DATA: io_addr=0xBE.
  - FILL: io_data=cmd_data on every slot.
  - STREAM: io_data=data_in. A slot whose `data_valid`=0 issues no write and does not consume the slot count; the block waits.
  - The remaining counter decrements on each write. On the write that takes it from 1 to 0, go to IDLE and pulse `done`.
- GAP: entered after each write when C_GAP>0. Count C_GAP `clk_en` slots, then return to the next write state.
- `data_ready` = DATA && op==STREAM && clk_en && data_valid && !gap. It is combinational and equals the io_wr of that cycle.
- Register indices 11–15 are emitted unchanged; the decoder ignores them.
- Address auto-increment is done by the VDP, not by this block.
- `busy` = state != IDLE.

## Timing
- Reset values: state IDLE, io_addr 0x00, io_data 0x00, io_wr 0, busy 0, done 0, data_ready 0, cmd_ready 1, counters 0.
- io_addr/io_data are registered and stable for the whole time a write state is held.
- io_wr = (state∈{CTRL0,CTRL1,DATA}) && clk_en (&& data_valid in STREAM DATA). It is high for exactly the clk_en cycle and never in two consecutive clk cycles.
- Accept at cycle N: first io_wr at the first clk_en at or after N+1.
- A clk_en in cycle N itself is not used.
- With C_GAP=0, consecutive writes occupy consecutive clk_en slots.
- `done` is asserted the cycle after the final io_wr. `cmd_ready` rises in the same cycle as `done`. A new command can be accepted in that cycle.
- Total slots per command (C_GAP=0, no stream stalls): 2 + len.
- The VDP control latch has no resync. reset_n must be asserted together with the VDP reset (n_hard_reset). If reset_n is asserted mid-command (e.g. between CTRL0 and CTRL1), the block returns to IDLE on the next clk edge, io_wr=0, and no further writes occur.
- C_LEN_BITS=14 allows up to 16383 bytes; a full 16 KiB fill uses two commands.

## Test plan
- SETREG reg=1, data=0x60, clk_en every 7 clocks:
  - io_wr pulses: (0xBF,0x60), then (0xBF,0x81), 7 clocks apart.
  - done pulse 1 cycle after the second write.
- SETADDR addr=0x3F00: writes (0xBF,0x00), (0xBF,0x7F); no 0xBE write; busy low afterwards.
- FILL addr=0x0000, data=0xAA, len=4:
  - exactly 6 writes: 0xBF×2, then 0xBE×4 of 0xAA.
  - done after the 6th; len=0 variant gives 2 writes only.
- STREAM len=3, data_valid deasserted for 2 slots before the second byte:
  - bytes 0x11, 0x22, 0x33 appear in order, with no write in the stalled slots.
  - data_ready pulses exactly 3 times, coincident with io_wr.
- C_GAP=2 FILL len=2: exactly two idle clk_en slots between every pair of writes (4 writes, 6 gap slots).
- reset_n low for one clock between the CTRL0 and CTRL1 writes:
  - no further io_wr.
  - outputs at reset values.
  - cmd_ready=1 on the next cycle.
  - a new SETREG then completes normally.
